uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` serializer between `NUM_REQ` byte requesters. It accepts one byte at a time from the winning requester and drives the serializer's `i_Tx_DV`/`i_Tx_Data` with a single-cycle strobe. It then waits for the serializer's `o_Tx_Done`, reports completion to the owner and enforces a guard gap before the next grant. It sits between the command/packet logic and the `uart_tx` instance.

---
 rtl/uart_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer that shares one uart_tx serializer between NUM_REQ byte requesters.
// Define UART_ARB_FIXED_PRIO_EN to switch to fixed priority, where the lowest set index always wins.
module uart_tx_arbiter #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 8,
   parameter  int GAP_CLKS   = 2,
   localparam int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                          i_Clock,
   input  logic                          i_Rst_L,
   input  logic [NUM_REQ-1:0]            i_Req_DV,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data,
   output logic [NUM_REQ-1:0]            o_Req_Ack,
   output logic [NUM_REQ-1:0]            o_Req_Done,
   output logic                          o_Tx_DV,
   output logic [DATA_WIDTH-1:0]         o_Tx_Data,
   input  logic                          i_Tx_Active,
   input  logic                          i_Tx_Done,
   output logic [IDX_W-1:0]              o_Grant_Idx,
   output logic                          o_Busy
);

   localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      GAP
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        last_q, last_d;
   logic [IDX_W-1:0]        grantIdx_q, grantIdx_d;
   logic [GAP_W-1:0]        gapCnt_q, gapCnt_d;
   logic [DATA_WIDTH-1:0]   txData_q, txData_d;
   logic [NUM_REQ-1:0]      reqAck_q, reqAck_d;
   logic [NUM_REQ-1:0]      reqDone_q, reqDone_d;
   logic                    txDv_q, txDv_d;
   logic                    busy_q, busy_d;

   logic                    grantNow;
   logic [IDX_W-1:0]        winner;

   // A grant needs an idle serializer, so an in-flight frame that survived a reset is never clobbered.
   assign grantNow = (state_q == IDLE) && !i_Tx_Active && (|i_Req_DV);

`ifdef UART_ARB_FIXED_PRIO_EN
   always_comb begin
      winner = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_Req_DV[k]) begin
            winner = IDX_W'(k);
         end
      end
   end
`else
   logic [IDX_W-1:0]        rrStart;
   logic [IDX_W-1:0]        rrOffset;
   logic [IDX_W:0]          rrSum;
   logic [2*NUM_REQ-1:0]    reqDouble;
   logic [NUM_REQ-1:0]      reqRot;

   // Rotate the request vector so the search starts just past the previous winner.
   always_comb begin
      rrStart   = (last_q == IDX_W'(NUM_REQ - 1)) ? '0 : last_q + IDX_W'(1);
      reqDouble = {i_Req_DV, i_Req_DV};
      reqRot    = NUM_REQ'(reqDouble >> rrStart);
      rrOffset  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (reqRot[k]) begin
            rrOffset = IDX_W'(k);
         end
      end
      rrSum = {1'b0, rrStart} + {1'b0, rrOffset};
      if (rrSum >= (IDX_W + 1)'(NUM_REQ)) begin
         rrSum = rrSum - (IDX_W + 1)'(NUM_REQ);
      end
      winner = rrSum[IDX_W-1:0];
   end
`endif

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q    <= IDLE;
         last_q     <= IDX_W'(NUM_REQ - 1);
         grantIdx_q <= '0;
         gapCnt_q   <= '0;
         txData_q   <= '0;
         reqAck_q   <= '0;
         reqDone_q  <= '0;
         txDv_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grantIdx_q <= grantIdx_d;
         gapCnt_q   <= gapCnt_d;
         txData_q   <= txData_d;
         reqAck_q   <= reqAck_d;
         reqDone_q  <= reqDone_d;
         txDv_q     <= txDv_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grantNow) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_Tx_Done) begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (gapCnt_q == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Every output is computed one cycle ahead so nothing reaches a port combinationally from an input.
   always_comb begin
      last_d     = last_q;
      grantIdx_d = grantIdx_q;
      txData_d   = txData_q;
      gapCnt_d   = gapCnt_q;
      reqAck_d   = '0;
      reqDone_d  = '0;
      txDv_d     = (state_q == ISSUE);
      busy_d     = (state_d != IDLE);

      if (grantNow) begin
         grantIdx_d = winner;
`ifndef UART_ARB_FIXED_PRIO_EN
         last_d     = winner;
`endif
         for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == IDX_W'(k)) begin
               txData_d    = i_Req_Data[k*DATA_WIDTH +: DATA_WIDTH];
               reqAck_d[k] = 1'b1;
            end
         end
      end

      if ((state_q == WAIT_DONE) && i_Tx_Done) begin
         gapCnt_d = GAP_W'(GAP_CLKS - 1);
         for (int k = 0; k < NUM_REQ; k++) begin
            if (grantIdx_q == IDX_W'(k)) begin
               reqDone_d[k] = 1'b1;
            end
         end
      end else if ((state_q == GAP) && (gapCnt_q != '0)) begin
         gapCnt_d = gapCnt_q - GAP_W'(1);
      end
   end

   assign o_Req_Ack   = reqAck_q;
   assign o_Req_Done  = reqDone_q;
   assign o_Tx_DV     = txDv_q;
   assign o_Tx_Data   = txData_q;
   assign o_Grant_Idx = grantIdx_q;
   assign o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx timing model at 87 clocks per bit.
// Expected grant orders follow UART_ARB_FIXED_PRIO_EN when it is defined for the build.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int DATA_WIDTH   = 8;
   localparam int GAP_CLKS     = 2;
   localparam int IDX_W        = 2;
   localparam int CLKS_PER_BIT = 87;
   localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT;
   localparam int BUDGET       = FRAME_CLKS + 100;

   logic                          clk = 1'b0;
   logic                          rstN;
   logic [NUM_REQ-1:0]            reqDv;
   logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
   logic [NUM_REQ-1:0]            reqAck;
   logic [NUM_REQ-1:0]            reqDone;
   logic                          txDv;
   logic [DATA_WIDTH-1:0]         txData;
   logic                          txActive;
   logic                          txDone;
   logic [IDX_W-1:0]              grantIdx;
   logic                          busy;

   logic                          mActive = 1'b0;
   logic                          mDone   = 1'b0;
   int                            mCnt    = 0;
   logic                          tbActive = 1'b0;
   logic                          tbDone   = 1'b0;
   logic [7:0]                    txLog[$];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign txActive = mActive | tbActive;
   assign txDone   = mDone | tbDone;

   uart_tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH),
      .GAP_CLKS   (GAP_CLKS)
   ) dut (
      .i_Clock     (clk),
      .i_Rst_L     (rstN),
      .i_Req_DV    (reqDv),
      .i_Req_Data  (reqData),
      .o_Req_Ack   (reqAck),
      .o_Req_Done  (reqDone),
      .o_Tx_DV     (txDv),
      .o_Tx_Data   (txData),
      .i_Tx_Active (txActive),
      .i_Tx_Done   (txDone),
      .o_Grant_Idx (grantIdx),
      .o_Busy      (busy)
   );

   // Serializer stand-in: busy for one frame after a strobe, then a one-cycle done; it ignores the arbiter reset.
   always @(posedge clk) begin
      mDone <= 1'b0;
      if (mActive) begin
         if (mCnt == 1) begin
            mActive <= 1'b0;
            mDone   <= 1'b1;
         end
         mCnt <= mCnt - 1;
      end else if (txDv === 1'b1) begin
         mActive <= 1'b1;
         mCnt    <= FRAME_CLKS;
         txLog.push_back(txData);
      end
   end

   task automatic applyStimulus(input logic [NUM_REQ-1:0] dv, input logic [NUM_REQ*DATA_WIDTH-1:0] data);
      reqDv   = dv;
      reqData = data;
   endtask

   task automatic waitIdle(output bit ok);
      int n = 0;
      while ((busy !== 1'b0 || txActive !== 1'b0) && n < 3 * BUDGET) begin
         @(negedge clk);
         n++;
      end
      ok = (busy === 1'b0 && txActive === 1'b0);
   endtask

   task automatic waitAck(output bit ok);
      int n = 0;
      while (reqAck === '0 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      ok = (reqAck !== '0);
   endtask

   task automatic waitTxDone(output bit ok);
      int n = 0;
      while (txDone !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      ok = (txDone === 1'b1);
   endtask

   task automatic test_reset;
      rstN = 1'b0;
      applyStimulus('0, '0);
      repeat (3) @(negedge clk);
      checks++; if (reqAck !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ack got=%b exp=0000", reqAck); end
      checks++; if (reqDone !== 4'b0000) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0000", reqDone); end
      checks++; if (txDv !== 1'b0) begin failures++; $display("[TB] FAIL reset_txdv got=%b exp=0", txDv); end
      checks++; if (txData !== 8'h00) begin failures++; $display("[TB] FAIL reset_txdata got=%h exp=00", txData); end
      checks++; if (grantIdx !== 2'd0) begin failures++; $display("[TB] FAIL reset_grant got=%0d exp=0", grantIdx); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      rstN = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_after got=%b exp=0", busy); end
   endtask

   task automatic test_single_byte;
      bit ok;
      applyStimulus(4'b0100, 32'h00A5_0000);
      @(negedge clk);
      checks++; if (reqAck !== 4'b0100) begin failures++; $display("[TB] FAIL single_ack got=%b exp=0100", reqAck); end
      checks++; if (grantIdx !== 2'd2) begin failures++; $display("[TB] FAIL single_grant got=%0d exp=2", grantIdx); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_ack got=%b exp=1", busy); end
      checks++; if (txDv !== 1'b0) begin failures++; $display("[TB] FAIL single_dv_early got=%b exp=0", txDv); end
      applyStimulus(4'b0000, 32'h00A5_0000);
      @(negedge clk);
      checks++; if (txDv !== 1'b1) begin failures++; $display("[TB] FAIL single_dv got=%b exp=1", txDv); end
      checks++; if (txData !== 8'hA5) begin failures++; $display("[TB] FAIL single_data got=%h exp=a5", txData); end
      checks++; if (reqAck !== 4'b0000) begin failures++; $display("[TB] FAIL single_ack_pulse got=%b exp=0000", reqAck); end
      @(negedge clk);
      checks++; if (txDv !== 1'b0) begin failures++; $display("[TB] FAIL single_dv_pulse got=%b exp=0", txDv); end
      waitTxDone(ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL single_txdone_timeout got=0 exp=1"); end
      @(negedge clk);
      checks++; if (reqDone !== 4'b0100) begin failures++; $display("[TB] FAIL single_done got=%b exp=0100", reqDone); end
      checks++; if (txData !== 8'hA5) begin failures++; $display("[TB] FAIL single_data_hold got=%h exp=a5", txData); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_gap1 got=%b exp=1", busy); end
      @(negedge clk);
      checks++; if (reqDone !== 4'b0000) begin failures++; $display("[TB] FAIL single_done_pulse got=%b exp=0000", reqDone); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_gap2 got=%b exp=1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_drop got=%b exp=0", busy); end
   endtask

   task automatic test_round_robin;
      bit         ok;
      int         expIdx[5];
      logic [7:0] expByte[4];
      logic [7:0] got;
`ifdef UART_ARB_FIXED_PRIO_EN
      expIdx = '{0, 0, 0, 0, 0};
`else
      expIdx = '{0, 1, 2, 3, 0};
`endif
      expByte = '{8'h11, 8'h22, 8'h33, 8'h44};
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      txLog.delete();
      applyStimulus(4'b1111, 32'h4433_2211);
      for (int g = 0; g < 5; g++) begin
         waitAck(ok);
         checks++; if (reqAck !== (4'b0001 << expIdx[g])) begin failures++; $display("[TB] FAIL rr_ack%0d got=%b exp=%b", g, reqAck, 4'b0001 << expIdx[g]); end
         checks++; if (grantIdx !== expIdx[g][1:0]) begin failures++; $display("[TB] FAIL rr_grant%0d got=%0d exp=%0d", g, grantIdx, expIdx[g]); end
         if (g == 4) applyStimulus(4'b0000, 32'h4433_2211);
         @(negedge clk);
      end
      waitIdle(ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL rr_idle_timeout got=busy exp=idle"); end
      checks++; if (txLog.size() != 5) begin failures++; $display("[TB] FAIL rr_bytes got=%0d exp=5", txLog.size()); end
      for (int i = 0; i < 5; i++) begin
         got = (i < txLog.size()) ? txLog[i] : 8'hxx;
         checks++; if (got !== expByte[expIdx[i]]) begin failures++; $display("[TB] FAIL rr_line%0d got=%h exp=%h", i, got, expByte[expIdx[i]]); end
      end
   endtask

   task automatic test_late_arrival;
      bit ok;
      int earlyAcks = 0;
      applyStimulus(4'b0010, 32'h0000_5A00);
      waitAck(ok);
      checks++; if (reqAck !== 4'b0010) begin failures++; $display("[TB] FAIL late_ack1 got=%b exp=0010", reqAck); end
      applyStimulus(4'b0000, 32'h0000_5A00);
      repeat (4) @(negedge clk);
      applyStimulus(4'b1000, 32'hC300_0000);
      while (txDone !== 1'b1 && earlyAcks < BUDGET) begin
         if (reqAck !== 4'b0000) earlyAcks = earlyAcks + BUDGET;
         @(negedge clk);
         earlyAcks++;
      end
      checks++; if (txDone !== 1'b1 || earlyAcks >= BUDGET) begin failures++; $display("[TB] FAIL late_wait got=ack_or_timeout exp=no_ack"); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (reqAck !== 4'b0000) begin failures++; $display("[TB] FAIL late_gap%0d got=%b exp=0000", c, reqAck); end
      end
      @(negedge clk);
      checks++; if (reqAck !== 4'b1000) begin failures++; $display("[TB] FAIL late_ack3 got=%b exp=1000", reqAck); end
      checks++; if (grantIdx !== 2'd3) begin failures++; $display("[TB] FAIL late_grant got=%0d exp=3", grantIdx); end
      applyStimulus(4'b0000, 32'hC300_0000);
      waitIdle(ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL late_idle_timeout got=busy exp=idle"); end
   endtask

   task automatic test_reset_mid_frame;
      bit ok;
      int n = 0;
      int bad = 0;
      applyStimulus(4'b0010, 32'h0000_7700);
      waitAck(ok);
      applyStimulus(4'b0000, 32'h0000_7700);
      repeat (6) @(negedge clk);
      applyStimulus(4'b0001, 32'h0000_0066);
      rstN = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (grantIdx !== 2'd0) begin failures++; $display("[TB] FAIL midrst_grant got=%0d exp=0", grantIdx); end
      checks++; if (txData !== 8'h00) begin failures++; $display("[TB] FAIL midrst_data got=%h exp=00", txData); end
      @(negedge clk);
      rstN = 1'b1;
      while (txActive === 1'b1 && n < BUDGET) begin
         if (reqAck !== 4'b0000 || reqDone !== 4'b0000) bad++;
         @(negedge clk);
         n++;
      end
      checks++; if (bad != 0 || n >= BUDGET) begin failures++; $display("[TB] FAIL midrst_block got=%0d exp=0", bad); end
      checks++; if (reqAck !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_ack_early got=%b exp=0000", reqAck); end
      @(negedge clk);
      checks++; if (reqAck !== 4'b0001) begin failures++; $display("[TB] FAIL midrst_ack got=%b exp=0001", reqAck); end
      checks++; if (reqDone !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_done got=%b exp=0000", reqDone); end
      applyStimulus(4'b0000, 32'h0000_0066);
      @(negedge clk);
      checks++; if (txData !== 8'h66) begin failures++; $display("[TB] FAIL midrst_data_new got=%h exp=66", txData); end
      waitIdle(ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL midrst_idle_timeout got=busy exp=idle"); end
   endtask

   task automatic test_spurious_done;
      bit ok;
      tbDone = 1'b1;
      @(negedge clk);
      tbDone = 1'b0;
      checks++; if (reqDone !== 4'b0000) begin failures++; $display("[TB] FAIL spur_done got=%b exp=0000", reqDone); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL spur_busy got=%b exp=0", busy); end
      @(negedge clk);
      checks++; if (reqDone !== 4'b0000) begin failures++; $display("[TB] FAIL spur_done2 got=%b exp=0000", reqDone); end
      applyStimulus(4'b0100, 32'h0099_0000);
      @(negedge clk);
      checks++; if (reqAck !== 4'b0100) begin failures++; $display("[TB] FAIL spur_ack got=%b exp=0100", reqAck); end
      applyStimulus(4'b0000, 32'h0099_0000);
      waitIdle(ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL spur_idle_timeout got=busy exp=idle"); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_round_robin();
      test_late_arrival();
      test_reset_mid_frame();
      test_spurious_done();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got=running exp=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
